// File: rtl/video_pixel_packer.sv
// Packs a qualified pixel stream into little-endian 64-bit words, one frame per
// enabled vsync rising edge, padding partial words at line end and counting lines/words.
module video_pixel_packer #(
    parameter int PIX_W    = 8,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic             clk_100,
    input  logic             reset_n,
    input  logic             capture_en,
    input  logic             vsync_in,
    input  logic             href_in,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic             start_frame,
    output logic [63:0]      data_ddr,
    output logic             valid_data_ddr,
    output logic             frame_done,
    output logic [23:0]      frame_words,
    output logic             line_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int PPW    = 64 / PIX_W;
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PPW - 1);
    localparam logic [11:0]       H_LIMIT   = 12'(H_ACTIVE);
    localparam logic [11:0]       V_LAST    = 12'(V_ACTIVE - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t            r_state;
    logic              r_vsync_d;
    logic              r_href_d;
    logic [11:0]       r_pix_cnt;
    logic [11:0]       r_line_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic [63:0]       r_acc;
    logic [23:0]       r_word_cnt;
    logic              r_start_frame;
    logic [63:0]       r_data_ddr;
    logic              r_valid;
    logic              r_frame_done;
    logic [23:0]       r_frame_words;
    logic              r_line_err;
    logic              r_frame_err;

    logic              w_vs_rise;
    logic              w_hs_fall;
    logic              w_pix_strobe;
    logic              w_pad;
    logic [23:0]       w_words_at_eol;
    logic [63:0]       w_acc_ins;

    assign w_vs_rise      = vsync_in & ~r_vsync_d;
    assign w_hs_fall      = ~href_in & r_href_d;
    assign w_pix_strobe   = href_in & pix_valid;
    assign w_pad          = (r_slot != '0);
    assign w_words_at_eol = r_word_cnt + {23'd0, w_pad};

    // Accumulator with the current pixel dropped into its slot; other lanes keep history.
    for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
        assign w_acc_ins[gi*PIX_W +: PIX_W] = (r_slot == SLOT_W'(gi)) ? pix_in
                                                                       : r_acc[gi*PIX_W +: PIX_W];
    end

    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_vsync_d     <= 1'b0;
            r_href_d      <= 1'b0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_slot        <= '0;
            r_acc         <= '0;
            r_word_cnt    <= '0;
            r_start_frame <= 1'b0;
            r_data_ddr    <= '0;
            r_valid       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_words <= '0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_vsync_d     <= vsync_in;
            r_href_d      <= href_in;
            r_start_frame <= 1'b0;
            r_valid       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_vs_rise && capture_en) begin
                        r_state       <= S_ACTIVE;
                        r_start_frame <= 1'b1;
                        r_pix_cnt     <= '0;
                        r_line_cnt    <= '0;
                        r_slot        <= '0;
                        r_acc         <= '0;
                        r_word_cnt    <= '0;
                    end
                end

                S_ACTIVE: begin
                    if (w_vs_rise) begin
                        // Restart in place: partial word is discarded, frame_words untouched.
                        r_frame_err   <= 1'b1;
                        r_start_frame <= 1'b1;
                        r_pix_cnt     <= '0;
                        r_line_cnt    <= '0;
                        r_slot        <= '0;
                        r_acc         <= '0;
                        r_word_cnt    <= '0;
                    end else if (w_hs_fall) begin
                        if (w_pad) begin
                            r_data_ddr <= r_acc;
                            r_valid    <= 1'b1;
                        end
                        r_line_err <= (r_pix_cnt != H_LIMIT);
                        r_word_cnt <= w_words_at_eol;
                        r_line_cnt <= r_line_cnt + 12'd1;
                        r_pix_cnt  <= '0;
                        r_slot     <= '0;
                        r_acc      <= '0;
                        if (r_line_cnt == V_LAST) begin
                            r_frame_done  <= 1'b1;
                            r_frame_words <= w_words_at_eol;
                            r_state       <= S_IDLE;
                        end
                    end else if (w_pix_strobe) begin
                        if (r_pix_cnt != 12'hFFF) begin
                            r_pix_cnt <= r_pix_cnt + 12'd1;
                        end
                        if (r_pix_cnt < H_LIMIT) begin
                            if (r_slot == SLOT_LAST) begin
                                r_data_ddr <= w_acc_ins;
                                r_valid    <= 1'b1;
                                r_acc      <= '0;
                                r_slot     <= '0;
                                r_word_cnt <= r_word_cnt + 24'd1;
                            end else begin
                                r_acc  <= w_acc_ins;
                                r_slot <= r_slot + 1'b1;
                            end
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_frame    = r_start_frame;
    assign data_ddr       = r_data_ddr;
    assign valid_data_ddr = r_valid;
    assign frame_done     = r_frame_done;
    assign frame_words    = r_frame_words;
    assign line_err       = r_line_err;
    assign frame_err      = r_frame_err;
    assign busy           = (r_state == S_ACTIVE);

endmodule

// File: doc/video_pixel_packer.md
# video_pixel_packer

Packs the incoming pixel stream into 64-bit words for `sdram_write`, which stores them in DDR. Captures whole frames between vsync edges and only while capture is enabled. Pads partial words at line end and counts lines and pixels. Drives `start_frame`, `data_ddr` and `valid_data_ddr` on `clk_100`.

## Interface
- `PIX_W`, 8: pixel width in bits; 64 must be divisible by `PIX_W`. `PPW` = 64/`PIX_W`.
- `H_ACTIVE`, 1280: expected pixels per line, range 1..4095.
- `V_ACTIVE`, 720: lines per frame, range 1..4095.
- Clocking: one clock, `clk_100`; `reset_n` is synchronous, active-low.
- `clk_100`  in  1  system clock.
- `reset_n`  in  1  synchronous active-low reset.
- `capture_en`  in  1  level; capture frames while high.
- `vsync_in`  in  1  frame sync; a rising edge starts a frame.
- `href_in`  in  1  line-valid level.
- `pix_valid`  in  1  pixel strobe, qualified by `href_in`.
- `pix_in`  in  `PIX_W`  pixel data.
- `start_frame`  out  1  one-cycle pulse at the start of each captured frame.
- `data_ddr`  out  64  packed word.
- `valid_data_ddr`  out  1  one-cycle qualifier for `data_ddr`.
- `frame_done`  out  1  one-cycle pulse after the last line of a frame.
- `frame_words`  out  24  word count of the last completed frame, latched on `frame_done`.
- `line_err`  out  1  one-cycle pulse when a line's pixel count ≠ `H_ACTIVE`.
- `frame_err`  out  1  one-cycle pulse when vsync rises mid-frame.
- `busy`  out  1  high while in ACTIVE.

## Operation
- Edge detect: registered `vsync_d` and `href_d`.
  - `vs_rise` = `vsync_in` & !`vsync_d`.
  - `hs_fall` = !`href_in` & `href_d`.
- States:
  - IDLE: on `vs_rise` & `capture_en` → ACTIVE, pulse `start_frame`, clear all counters.
  - ACTIVE: pack pixels. After `V_ACTIVE` lines have completed → `frame_done`, latch `frame_words`, go to IDLE.
  - `capture_en` dropping mid-frame does not abort; the current frame completes.
- Pixel acceptance: a pixel is accepted when state is ACTIVE & `href_in` & `pix_valid` & `pix_cnt` < `H_ACTIVE`.
  - Pixels beyond `H_ACTIVE` are dropped; they are still counted for the `line_err` check (counter saturates at 4095).
- Packing is little-endian.
  - The k-th pixel of a word lands in bits [k·`PIX_W` +: `PIX_W`].
  - After `PPW` accepted pixels, a word is emitted and the slot index wraps to 0.
  - Slot index and pixel count reset at every line end.
- Line end (`hs_fall` in ACTIVE):
  - If the slot index ≠ 0, emit the partial word with unused upper bits zero.
  - Pulse `line_err` if the raw pixel count ≠ `H_ACTIVE`.
  - Increment `line_cnt`.
  - An `hs_fall` in IDLE is ignored.
- `vs_rise` while ACTIVE:
  - Pulse `frame_err` and `start_frame` together.
  - Drop the partial word and restart all counters.
  - Remain in ACTIVE. `frame_done` is not pulsed and `frame_words` is not updated.
- Word counter: 24-bit, incremented on every `valid_data_ddr`, cleared at frame start.
  - Nominal value at frame end: `V_ACTIVE`·ceil(`H_ACTIVE`/`PPW`).

## Timing
- Reset: every register and output is 0. State = IDLE; `data_ddr`, `frame_words` and all counters are 0.
- `start_frame` is high in cycle T+1, where cycle T is the one in which `vs_rise` is sampled.
- A word completed by the pixel accepted in cycle T is presented with `valid_data_ddr`=1 in T+1, for exactly one cycle.
- A padded word for an `hs_fall` sampled in cycle T is presented in T+1.
  - No collision is possible: a pixel cannot be accepted in the same cycle `hs_fall` is sampled.
- `line_err` is high in T+1 of the `hs_fall`.
- `frame_done` is high in T+1 of the final line's `hs_fall`, in the same cycle as that line's last padded word if there is one.
  - `frame_words` already includes that word in the same cycle.
- `data_ddr` holds its last value when `valid_data_ddr`=0.
- Reset asserted mid-frame: on the next edge, all outputs return to 0 and state returns to IDLE; no partial word is emitted.
- Throughput: one pixel per cycle sustained. There is no backpressure; the downstream FIFO absorbs bursts.

## Test plan
All scenarios use `PIX_W`=8, `H_ACTIVE`=20, `V_ACTIVE`=3.
- Nominal frame: `capture_en`=1, vsync pulse, 3 lines of 20 pixels with value = pixel index.
  - Required: `start_frame` once; 9 words.
  - Word 0 = 64'h0706050403020100.
  - Word 2 of each line = 64'h0000000013121110.
  - `frame_done` coincides with word 9; `frame_words`=9; no errors.
- Capture disabled: vsync with `capture_en`=0.
  - Required: no `start_frame`, no `valid_data_ddr`, `busy`=0.
- Short and long lines: line 1 has 18 pixels, line 2 has 22 pixels.
  - Required: `line_err` pulses for both lines.
  - Line 1 third word = 64'h0000000000001110.
  - Line 2 emits 3 words; pixels 20–21 are dropped.
- Mid-frame vsync: `vs_rise` after 1.5 lines.
  - Required: `frame_err` and `start_frame` in the same cycle; the partial word is not emitted.
  - The following full frame gives `frame_words`=9.
- `capture_en` dropped during line 2: frame completes with `frame_done` and `frame_words`=9; the next vsync is ignored.
- Reset mid-line: `reset_n`=0 for one cycle after 5 pixels.
  - Required: the next cycle shows all outputs at 0 and state IDLE; no data until the next enabled vsync.
